// File: rtl/dcache_rr_arbiter_pkg.sv
// Shared types and constants for the data-cache SRAM port arbiter.
// Holds the cache line layout, byte-enable type, lock bound and lock FSM states.
package dcache_rr_arbiter_pkg;

  localparam int unsigned DCACHE_TAG_WIDTH  = 44;
  localparam int unsigned DCACHE_LINE_WIDTH = 128;
  localparam int unsigned DCACHE_MAX_LOCK   = 4;

  typedef struct packed {
    logic [DCACHE_TAG_WIDTH-1:0]  tag;
    logic [DCACHE_LINE_WIDTH-1:0] data;
    logic                         valid;
  } cache_line_t;

  typedef logic [DCACHE_LINE_WIDTH/8-1:0] cl_be_t;

  typedef enum logic {
    LOCK_IDLE   = 1'b0,
    LOCK_LOCKED = 1'b1
  } lock_state_e;

  // Round-robin successor of a port index, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dcache_rr_arbiter_if.sv
// Requester-side bundle of the data-cache SRAM arbiter; names are from the arbiter's view.
// Handshake: a requester raises req_i with its payload and holds both until gnt_o is high;
// the access is taken in the cycle where req_i && gnt_o, and tag_i follows one cycle later.
interface dcache_rr_arbiter_if
  import dcache_rr_arbiter_pkg::*;
#(
  parameter int unsigned NR_PORTS         = 3,
  parameter int unsigned ADDR_WIDTH       = 64,
  parameter int unsigned DCACHE_SET_ASSOC = 8
);

  logic [NR_PORTS-1:0]                        req_i;
  logic [NR_PORTS-1:0][DCACHE_SET_ASSOC-1:0]  way_i;
  logic [NR_PORTS-1:0]                        lock_i;
  logic [NR_PORTS-1:0]                        gnt_o;
  logic [NR_PORTS-1:0][ADDR_WIDTH-1:0]        addr_i;
  cache_line_t [NR_PORTS-1:0]                 wdata_i;
  logic [NR_PORTS-1:0]                        we_i;
  cl_be_t [NR_PORTS-1:0]                      be_i;
  logic [NR_PORTS-1:0][DCACHE_TAG_WIDTH-1:0]  tag_i;
  logic [NR_PORTS-1:0]                        hit_valid_o;
  logic [DCACHE_SET_ASSOC-1:0]                hit_way_o;

  modport master (
    output req_i, way_i, lock_i, addr_i, wdata_i, we_i, be_i, tag_i,
    input  gnt_o, hit_valid_o, hit_way_o
  );

  modport slave (
    input  req_i, way_i, lock_i, addr_i, wdata_i, we_i, be_i, tag_i,
    output gnt_o, hit_valid_o, hit_way_o
  );

endinterface

// File: rtl/dcache_rr_arbiter_rr_prio_sel.sv
// Combinational round-robin pick: first request at or after ptr_i, wrapping.
// Ports in excl_i drop to lowest priority; they still win if nobody else requests.
module dcache_rr_arbiter_rr_prio_sel #(
  parameter  int unsigned N     = 3,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic [N-1:0]     excl_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);

  logic [N-1:0] w_pref;
  logic [N-1:0] w_pool;

  assign w_pref = req_i & ~excl_i;
  assign w_pool = (|w_pref) ? w_pref : req_i;

  // Pass one covers ptr..N-1, pass two supplies the wrap-around to 0..ptr-1.
  always_comb begin
    vld_o = 1'b0;
    idx_o = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (!vld_o && w_pool[i] && (i >= int'(ptr_i))) begin
        vld_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      if (!vld_o && w_pool[i]) begin
        vld_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
    gnt_o = vld_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/dcache_rr_arbiter.sv
// Round-robin arbiter for the shared data-cache tag/data SRAM port with bounded RMW locks.
// Tracks the granted reader across the one-cycle tag latency and returns per-port hits.
module dcache_rr_arbiter
  import dcache_rr_arbiter_pkg::*;
#(
  parameter int unsigned NR_PORTS         = 3,
  parameter int unsigned ADDR_WIDTH       = 64,
  parameter int unsigned DCACHE_SET_ASSOC = 8,
  parameter int unsigned MAX_LOCK         = DCACHE_MAX_LOCK
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  dcache_rr_arbiter_if.slave                 bus,
  input  cache_line_t [DCACHE_SET_ASSOC-1:0] rdata_i,
  output cache_line_t [DCACHE_SET_ASSOC-1:0] rdata_o,
  output logic [DCACHE_SET_ASSOC-1:0]        req_o,
  output logic [ADDR_WIDTH-1:0]              addr_o,
  output cache_line_t                        wdata_o,
  output logic                               we_o,
  output cl_be_t                             be_o,
  output lock_state_e                        dbg_state_o
);

  localparam int unsigned IDX_W = $clog2(NR_PORTS);
  localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

  lock_state_e             r_state;
  logic [IDX_W-1:0]        r_rr_ptr;
  logic [IDX_W-1:0]        r_lock_owner;
  logic [CNT_W-1:0]        r_lock_cnt;
  logic [IDX_W-1:0]        r_rd_id;
  logic                    r_rd_vld;

  logic                    w_lock_hold;
  logic                    w_lock_expire;
  logic [IDX_W-1:0]        w_sel_ptr;
  logic [NR_PORTS-1:0]     w_sel_excl;
  logic [NR_PORTS-1:0]     w_req;
  logic [NR_PORTS-1:0]     w_sel_gnt;
  logic [IDX_W-1:0]        w_sel_idx;
  logic                    w_sel_vld;
  logic                    w_win_vld;
  logic [IDX_W-1:0]        w_win_idx;
  logic [IDX_W-1:0]        w_next_ptr;
  logic [DCACHE_TAG_WIDTH-1:0] w_sel_tag;

  // The owner keeps the port only while it still asks for it and the budget lasts.
  assign w_lock_hold   = rst_ni && (r_state == LOCK_LOCKED) && bus.req_i[r_lock_owner]
                         && bus.lock_i[r_lock_owner] && (r_lock_cnt < CNT_W'(MAX_LOCK));
  assign w_lock_expire = (r_state == LOCK_LOCKED) && (r_lock_cnt == CNT_W'(MAX_LOCK));
  assign w_sel_ptr     = w_lock_expire ? IDX_W'(rr_next(32'(r_lock_owner), NR_PORTS)) : r_rr_ptr;
  assign w_sel_excl    = w_lock_expire ? (NR_PORTS'(1) << r_lock_owner) : '0;
  assign w_req         = rst_ni ? bus.req_i : '0;

  dcache_rr_arbiter_rr_prio_sel #(.N(NR_PORTS)) u_prio_sel (
    .req_i  (w_req),
    .ptr_i  (w_sel_ptr),
    .excl_i (w_sel_excl),
    .gnt_o  (w_sel_gnt),
    .idx_o  (w_sel_idx),
    .vld_o  (w_sel_vld)
  );

  assign w_win_vld  = w_lock_hold || w_sel_vld;
  assign w_win_idx  = w_lock_hold ? r_lock_owner : w_sel_idx;
  assign w_next_ptr = IDX_W'(rr_next(32'(w_win_idx), NR_PORTS));
  assign bus.gnt_o  = w_win_vld ? (NR_PORTS'(1) << w_win_idx) : '0;
  assign rdata_o    = rdata_i;
  assign dbg_state_o = r_state;

  always_comb begin
    req_o   = '0;
    addr_o  = '0;
    wdata_o = '0;
    we_o    = 1'b0;
    be_o    = '0;
    if (w_win_vld) begin
      req_o   = bus.way_i[w_win_idx];
      addr_o  = bus.addr_i[w_win_idx];
      wdata_o = bus.wdata_i[w_win_idx];
      we_o    = bus.we_i[w_win_idx];
      be_o    = bus.be_i[w_win_idx];
    end
  end

  // Tag phase: compare the previous cycle's read against the SRAM output.
  always_comb begin
    bus.hit_valid_o = '0;
    bus.hit_valid_o[r_rd_id] = r_rd_vld;
    w_sel_tag = bus.tag_i[r_rd_id];
    for (int j = 0; j < int'(DCACHE_SET_ASSOC); j++) begin
      bus.hit_way_o[j] = r_rd_vld && rdata_i[j].valid && (rdata_i[j].tag == w_sel_tag);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= LOCK_IDLE;
      r_rr_ptr     <= '0;
      r_lock_owner <= '0;
      r_lock_cnt   <= '0;
      r_rd_id      <= '0;
      r_rd_vld     <= 1'b0;
    end else begin
      if (w_win_vld && !w_lock_hold) r_rr_ptr <= w_next_ptr;
      r_rd_vld <= w_win_vld && !bus.we_i[w_win_idx];
      if (w_win_vld) r_rd_id <= w_win_idx;
      case (r_state)
        LOCK_IDLE: begin
          if (w_win_vld && bus.lock_i[w_win_idx]) begin
            r_state      <= LOCK_LOCKED;
            r_lock_owner <= w_win_idx;
            r_lock_cnt   <= CNT_W'(1);
          end
        end
        LOCK_LOCKED: begin
          if (w_lock_hold) begin
            r_lock_cnt <= r_lock_cnt + CNT_W'(1);
          end else begin
            r_state    <= LOCK_IDLE;
            r_lock_cnt <= '0;
          end
        end
        default: r_state <= LOCK_IDLE;
      endcase
    end
  end

  a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(bus.gnt_o));
  a_hit_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (|bus.hit_valid_o) |-> $onehot0(bus.hit_way_o));
  a_lock_cnt_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_lock_cnt <= CNT_W'(MAX_LOCK));

endmodule

// File: tb/tb_dcache_rr_arbiter.sv
// Directed bench for dcache_rr_arbiter: round-robin order, tag hits, writes, locks, reset.
module tb_dcache_rr_arbiter;
  import dcache_rr_arbiter_pkg::*;

  localparam int unsigned NP   = 3;
  localparam int unsigned AW   = 64;
  localparam int unsigned WAYS = 8;

  logic clk;
  logic rst_n;

  dcache_rr_arbiter_if #(.NR_PORTS(NP), .ADDR_WIDTH(AW), .DCACHE_SET_ASSOC(WAYS)) bus ();

  cache_line_t [WAYS-1:0] rdata_i;
  cache_line_t [WAYS-1:0] rdata_o;
  logic [WAYS-1:0]        req_o;
  logic [AW-1:0]          addr_o;
  cache_line_t            wdata_o;
  logic                   we_o;
  cl_be_t                 be_o;
  lock_state_e            dbg_state;

  int n_tests;
  int n_fail;

  dcache_rr_arbiter #(
    .NR_PORTS(NP), .ADDR_WIDTH(AW), .DCACHE_SET_ASSOC(WAYS), .MAX_LOCK(4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus         (bus),
    .rdata_i     (rdata_i),
    .rdata_o     (rdata_o),
    .req_o       (req_o),
    .addr_o      (addr_o),
    .wdata_o     (wdata_o),
    .we_o        (we_o),
    .be_o        (be_o),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic clear_inputs();
    bus.req_i   = '0;
    bus.way_i   = '0;
    bus.lock_i  = '0;
    bus.addr_i  = '0;
    bus.wdata_i = '0;
    bus.we_i    = '0;
    bus.be_i    = '0;
    bus.tag_i   = '0;
    rdata_i     = '0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic set_port_payload();
    for (int p = 0; p < int'(NP); p++) begin
      bus.addr_i[p] = AW'(32'h100 * (p + 1));
      bus.way_i[p]  = WAYS'(8'h1 << p);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    if (bus.gnt_o !== '0 || req_o !== '0 || addr_o !== '0 || we_o !== 1'b0 ||
        be_o !== '0 || wdata_o !== '0) begin
      $display("FAIL reset_sram gnt=%b req_o=%h addr=%h we=%b got nonzero, required all 0",
               bus.gnt_o, req_o, addr_o, we_o);
      n_fail++;
    end
    n_tests++;
    if (bus.hit_valid_o !== '0 || bus.hit_way_o !== '0 || dbg_state !== LOCK_IDLE) begin
      $display("FAIL reset_hit hit_valid=%b hit_way=%h state=%0d required 0/0/IDLE",
               bus.hit_valid_o, bus.hit_way_o, dbg_state);
      n_fail++;
    end
    n_tests++;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    if (bus.gnt_o !== '0 || bus.hit_valid_o !== '0) begin
      $display("FAIL reset_release gnt=%b hit_valid=%b required 0/0", bus.gnt_o, bus.hit_valid_o);
      n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_rr_reads();
    logic [NP-1:0] exp_gnt [7];
    logic [NP-1:0] exp_hv;
    int            w;
    exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b000};
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      clear_inputs();
      set_port_payload();
      bus.req_i = (c < 6) ? 3'b111 : 3'b000;
      #1;
      if (bus.gnt_o !== exp_gnt[c]) begin
        $display("FAIL rr_gnt c=%0d got=%b required=%b", c, bus.gnt_o, exp_gnt[c]);
        n_fail++;
      end
      n_tests++;
      exp_hv = (c > 0) ? exp_gnt[c-1] : 3'b000;
      if (bus.hit_valid_o !== exp_hv || bus.hit_way_o !== '0) begin
        $display("FAIL rr_hit_valid c=%0d got=%b/%h required=%b/00", c, bus.hit_valid_o,
                 bus.hit_way_o, exp_hv);
        n_fail++;
      end
      n_tests++;
      if (c < 6) begin
        w = c % 3;
        if (addr_o !== AW'(32'h100 * (w + 1)) || req_o !== WAYS'(8'h1 << w)) begin
          $display("FAIL rr_mux c=%0d addr=%h req_o=%h required addr=%h req_o=%h", c, addr_o,
                   req_o, 32'h100 * (w + 1), 8'h1 << w);
          n_fail++;
        end
        n_tests++;
      end
    end
  endtask

  task automatic test_hit();
    @(negedge clk);
    clear_inputs();
    bus.req_i[1]  = 1'b1;
    bus.addr_i[1] = AW'(32'h40);
    bus.way_i[1]  = 8'hFF;
    #1;
    if (bus.gnt_o !== 3'b010 || addr_o !== AW'(32'h40) || req_o !== 8'hFF || we_o !== 1'b0) begin
      $display("FAIL hit_req gnt=%b addr=%h req_o=%h we=%b required 010/40/ff/0", bus.gnt_o,
               addr_o, req_o, we_o);
      n_fail++;
    end
    n_tests++;
    @(negedge clk);
    clear_inputs();
    rdata_i[3].tag   = DCACHE_TAG_WIDTH'(32'h12);
    rdata_i[3].valid = 1'b1;
    rdata_i[5].tag   = DCACHE_TAG_WIDTH'(32'h13);
    rdata_i[5].valid = 1'b1;
    bus.tag_i[1]     = DCACHE_TAG_WIDTH'(32'h12);
    #1;
    if (bus.hit_valid_o !== 3'b010 || bus.hit_way_o !== 8'h08) begin
      $display("FAIL hit_way hit_valid=%b hit_way=%h required 010/08", bus.hit_valid_o,
               bus.hit_way_o);
      n_fail++;
    end
    n_tests++;
    if (rdata_o !== rdata_i) begin
      $display("FAIL rdata_pass got=%h required=%h", rdata_o, rdata_i);
      n_fail++;
    end
    n_tests++;
    idle_cycle();
    #1;
    if (bus.hit_valid_o !== '0) begin
      $display("FAIL hit_strobe_len hit_valid=%b required 000", bus.hit_valid_o);
      n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_write();
    cache_line_t wl;
    wl       = '0;
    wl.tag   = DCACHE_TAG_WIDTH'(32'h5A);
    wl.data  = {4{32'hDEADBEEF}};
    wl.valid = 1'b1;
    @(negedge clk);
    clear_inputs();
    bus.req_i[0]   = 1'b1;
    bus.we_i[0]    = 1'b1;
    bus.way_i[0]   = 8'h24;
    bus.addr_i[0]  = AW'(32'h1000);
    bus.wdata_i[0] = wl;
    bus.be_i[0]    = 16'hF0F0;
    #1;
    if (bus.gnt_o !== 3'b001 || req_o !== 8'h24 || we_o !== 1'b1 || be_o !== 16'hF0F0 ||
        wdata_o !== wl || addr_o !== AW'(32'h1000)) begin
      $display("FAIL write_req gnt=%b req_o=%h we=%b be=%h addr=%h required 001/24/1/f0f0/1000",
               bus.gnt_o, req_o, we_o, be_o, addr_o);
      n_fail++;
    end
    n_tests++;
    @(negedge clk);
    clear_inputs();
    rdata_i[2].tag   = DCACHE_TAG_WIDTH'(32'h5A);
    rdata_i[2].valid = 1'b1;
    bus.tag_i[0]     = DCACHE_TAG_WIDTH'(32'h5A);
    #1;
    if (bus.hit_valid_o !== '0 || bus.hit_way_o !== '0) begin
      $display("FAIL write_no_hit hit_valid=%b hit_way=%h required 000/00", bus.hit_valid_o,
               bus.hit_way_o);
      n_fail++;
    end
    n_tests++;
    idle_cycle();
  endtask

  task automatic test_lock();
    logic [NP-1:0] exp_gnt [7];
    logic [NP-1:0] exp_hv;
    exp_gnt = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b000};
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      clear_inputs();
      set_port_payload();
      bus.req_i  = (c == 0) ? 3'b100 : ((c < 6) ? 3'b111 : 3'b000);
      bus.lock_i = (c < 6) ? 3'b100 : 3'b000;
      #1;
      if (bus.gnt_o !== exp_gnt[c]) begin
        $display("FAIL lock_gnt c=%0d got=%b required=%b", c, bus.gnt_o, exp_gnt[c]);
        n_fail++;
      end
      n_tests++;
      exp_hv = (c > 0) ? exp_gnt[c-1] : 3'b000;
      if (bus.hit_valid_o !== exp_hv) begin
        $display("FAIL lock_hit_valid c=%0d got=%b required=%b", c, bus.hit_valid_o, exp_hv);
        n_fail++;
      end
      n_tests++;
      if (c == 4 && dbg_state !== LOCK_LOCKED) begin
        $display("FAIL lock_state_held state=%0d required LOCKED", dbg_state);
        n_fail++;
      end
      if (c == 4) n_tests++;
      if (c == 6 && dbg_state !== LOCK_IDLE) begin
        $display("FAIL lock_state_loser state=%0d required IDLE", dbg_state);
        n_fail++;
      end
      if (c == 6) n_tests++;
    end
  endtask

  task automatic test_lock_release();
    @(negedge clk);
    clear_inputs();
    set_port_payload();
    bus.req_i  = 3'b100;
    bus.lock_i = 3'b100;
    #1;
    if (bus.gnt_o !== 3'b100) begin
      $display("FAIL release_first got=%b required=100", bus.gnt_o);
      n_fail++;
    end
    n_tests++;
    @(negedge clk);
    bus.req_i  = 3'b111;
    bus.lock_i = 3'b000;
    #1;
    if (bus.gnt_o !== 3'b001) begin
      $display("FAIL release_rearb got=%b required=001", bus.gnt_o);
      n_fail++;
    end
    n_tests++;
    idle_cycle();
    #1;
    if (dbg_state !== LOCK_IDLE) begin
      $display("FAIL release_state state=%0d required IDLE", dbg_state);
      n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_reset_mid_lock();
    @(negedge clk);
    clear_inputs();
    set_port_payload();
    bus.req_i  = 3'b010;
    bus.lock_i = 3'b010;
    @(negedge clk);
    bus.req_i = 3'b111;
    #1;
    if (bus.gnt_o !== 3'b010 || dbg_state !== LOCK_LOCKED) begin
      $display("FAIL midlock_hold got=%b state=%0d required 010/LOCKED", bus.gnt_o, dbg_state);
      n_fail++;
    end
    n_tests++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    if (bus.gnt_o !== '0 || req_o !== '0 || addr_o !== '0 || bus.hit_valid_o !== '0 ||
        dbg_state !== LOCK_IDLE) begin
      $display("FAIL midlock_reset gnt=%b req_o=%h addr=%h hit_valid=%b state=%0d required 0",
               bus.gnt_o, req_o, addr_o, bus.hit_valid_o, dbg_state);
      n_fail++;
    end
    n_tests++;
    @(negedge clk);
    rst_n      = 1'b1;
    bus.req_i  = 3'b110;
    bus.lock_i = 3'b000;
    #1;
    if (bus.gnt_o !== 3'b010) begin
      $display("FAIL midlock_after got=%b required=010", bus.gnt_o);
      n_fail++;
    end
    n_tests++;
    idle_cycle();
  endtask

  task automatic test_invalid_tag();
    @(negedge clk);
    clear_inputs();
    set_port_payload();
    bus.req_i[0] = 1'b1;
    #1;
    if (bus.gnt_o !== 3'b001) begin
      $display("FAIL inv_gnt got=%b required=001", bus.gnt_o);
      n_fail++;
    end
    n_tests++;
    @(negedge clk);
    clear_inputs();
    rdata_i[6].tag   = DCACHE_TAG_WIDTH'(32'h77);
    rdata_i[6].valid = 1'b0;
    bus.tag_i[0]     = DCACHE_TAG_WIDTH'(32'h77);
    #1;
    if (bus.hit_valid_o !== 3'b001 || bus.hit_way_o !== '0) begin
      $display("FAIL inv_hit hit_valid=%b hit_way=%h required 001/00", bus.hit_valid_o,
               bus.hit_way_o);
      n_fail++;
    end
    n_tests++;
    idle_cycle();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    clear_inputs();
    test_reset();
    test_rr_reads();
    test_hit();
    test_write();
    test_lock();
    test_lock_release();
    test_reset_mid_lock();
    test_invalid_tag();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_rr_arbiter.md
Name: dcache_rr_arbiter

Overview:
- Round-robin arbiter and access sequencer for the shared data-cache tag/data SRAM port. Replaces fixed-priority selection.
- Multiplexes NR_PORTS requesters onto one SRAM request and supports bounded multi-cycle locks for atomic read-modify-write.
- Tracks the granted port across the one-cycle tag latency and returns per-port hit information with a valid strobe.
- Sits between the cache controllers (miss handler, load/store units) and the SRAM wrappers.

Parameters:
- NR_PORTS, 3, number of requesters; must be at least 2.
- ADDR_WIDTH, 64, index/offset address width.
- DCACHE_SET_ASSOC, 8, number of ways.
- TAG_WIDTH, ariane_pkg::DCACHE_TAG_WIDTH, tag width.
- l_data_t, std_cache_pkg::cache_line_t, line type; has fields .tag and .valid.
- l_be_t, std_cache_pkg::cl_be_t, byte-enable type.
- MAX_LOCK, 4, maximum consecutive cycles one port may hold a lock.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_i  in  NR_PORTS  per-port access request
- way_i  in  NR_PORTS x DCACHE_SET_ASSOC  way enable mask per port
- lock_i  in  NR_PORTS  keep grant next cycle (RMW)
- gnt_o  out  NR_PORTS  one-hot grant, combinational
- addr_i  in  NR_PORTS x ADDR_WIDTH  address
- wdata_i  in  NR_PORTS x l_data_t  write data
- we_i  in  NR_PORTS  write enable
- be_i  in  NR_PORTS x l_be_t  byte enables
- tag_i  in  NR_PORTS x TAG_WIDTH  compare tag, presented the cycle after grant
- hit_valid_o  out  NR_PORTS  one-cycle strobe: hit_way_o belongs to this port
- hit_way_o  out  DCACHE_SET_ASSOC  per-way hit
- rdata_o  out  DCACHE_SET_ASSOC x l_data_t  pass-through of rdata_i
- req_o  out  DCACHE_SET_ASSOC  SRAM way requests
- addr_o  out  ADDR_WIDTH  SRAM address
- wdata_o  out  l_data_t  SRAM write data
- we_o  out  1  SRAM write enable
- be_o  out  l_be_t  SRAM byte enables
- rdata_i  in  DCACHE_SET_ASSOC x l_data_t  SRAM read data, one cycle after req_o

Behaviour:
- Reset (async): rr_ptr_q=0, lock_owner_q=none, lock_cnt_q=0, rd_id_q=0, rd_vld_q=0. With no requests all outputs are 0: gnt_o, req_o, addr_o, wdata_o, we_o, be_o, hit_valid_o, hit_way_o.
- Arbitration (combinational):
  - If a lock is active and the owner's req_i is high, the owner wins.
  - Otherwise the first requesting port at or after rr_ptr_q wins, searching upward with wrap-around.
  - gnt_o is one-hot or zero.
- Winner drives the SRAM: req_o=way_i[w], and addr/wdata/we/be from port w. With no winner, all SRAM outputs are 0.
- Pointer update: on a grant without lock continuation, rr_ptr_q <= (w+1) mod NR_PORTS. While a lock is held, the pointer is frozen.
- Lock state machine, states IDLE and LOCKED:
  - IDLE -> LOCKED when granted port w has lock_i[w]=1. Set owner=w, lock_cnt=1.
  - LOCKED, owner req and lock both high, lock_cnt<MAX_LOCK: keep the grant and increment lock_cnt.
  - LOCKED, lock_cnt==MAX_LOCK: the lock is ignored for that cycle. Round-robin arbitrates with the owner excluded from priority (pointer = owner+1). Go to IDLE.
  - LOCKED, owner drops req or lock: go to IDLE the same cycle, and that cycle is arbitrated normally.
- Tag phase:
  - rd_vld_q <= any grant with we=0; rd_id_q <= w.
  - Next cycle: hit_valid_o[rd_id_q]=rd_vld_q. sel_tag=tag_i[rd_id_q]. hit_way_o[j]=rd_vld_q & rdata_i[j].valid & (rdata_i[j].tag==sel_tag).
  - Write grants produce no hit_valid_o.
- Back-to-back grants are pipelined: cycle N's tag phase overlaps cycle N+1's request phase. Throughput is one access per cycle.
- Simultaneous events: a lock request from a port that has not won is ignored.
- rdata_o=rdata_i always.
- Assertions (non-synth): gnt_o onehot0; hit_way_o onehot0 whenever hit_valid_o is nonzero; lock_cnt_q<=MAX_LOCK.

Decomposition:
- std_cache_pkg holds cache_line_t, cl_be_t and a new DCACHE_MAX_LOCK constant. TAG_WIDTH comes from ariane_pkg.
- One sub-module, rr_prio_sel: combinational round-robin pick from (req vector, pointer, exclude mask), returning a one-hot grant plus a binary index.
- The lock FSM, pipeline registers and mux stay in the top module.

Test Plan:
- All three ports request a read for 6 cycles -> grants 0,1,2,0,1,2. hit_valid_o follows each grant by one cycle on the same port.
- Port1 reads addr 0x40 with way_i=0xFF; next cycle rdata_i[3]={tag=0x12,valid=1} and tag_i[1]=0x12 -> hit_valid_o=3'b010, hit_way_o=8'h08.
- Port0 write (we=1) -> req_o=way_i[0] and we_o=1. Next cycle hit_valid_o=0 and hit_way_o=0.
- Port2 holds req+lock, ports 0 and 1 also requesting, MAX_LOCK=4 -> port2 granted 4 cycles, then port0, then port1. No starvation.
- Reset asserted mid-lock -> outputs 0 immediately. After release, the first grant goes to the lowest requesting port (ptr=0).
- Matching tag with valid=0 -> hit_way_o=0, hit_valid_o still strobes for that port.
